// File: rtl/pkt_axis_arbiter_pkg.sv
// Shared constants and FSM encoding for the packet-granular AXI-stream arbiter.
package pkt_axis_arbiter_pkg;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned TAG_MSB = 63;
  localparam int unsigned TAG_LSB = 56;
  localparam int unsigned LEN_MSB = 31;
  localparam int unsigned LEN_LSB = 0;

  localparam logic [TAG_MSB-TAG_LSB:0] ROUTE_TAG = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/pkt_axis_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_gnt wins.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_gnt,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [IW:0] cand;
  logic        found;

  // Scan offsets 1..N from the last owner; modulo done by one conditional subtract.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = {1'b0, last_gnt} + (IW+1)'(i);
      if (cand >= N_W) cand = cand - N_W;
      if (!found && req[cand[IW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
    gnt[gnt_idx] = found;
  end

endmodule

// File: rtl/pkt_axis_arbiter.sv
// Round-robin packet arbiter merging N_PORTS OpenFC-framed AXI streams onto one sink.
// Optional stall watchdog enabled by defining PKT_ARB_WDOG_EN.
module pkt_axis_arbiter
  import pkt_axis_arbiter_pkg::*;
#(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [DATA_W*N_PORTS-1:0]   S_AXIS_TDATA,
  input  logic [N_PORTS-1:0]          S_AXIS_TVALID,
  output logic [N_PORTS-1:0]          S_AXIS_TREADY,
  output logic [DATA_W-1:0]           M_AXIS_TDATA,
  output logic                        M_AXIS_TVALID,
  output logic                        M_AXIS_TLAST,
  input  logic                        M_AXIS_TREADY,
  output logic [N_PORTS-1:0]          GRANT,
  output logic                        ERR
);

  localparam int unsigned IW = $clog2(N_PORTS);

  if (N_PORTS < 2 || N_PORTS > 16) begin : g_bad_ports
    $error("pkt_axis_arbiter: N_PORTS must be 2..16");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("pkt_axis_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_t               state, state_nxt;
  logic [N_PORTS-1:0]       grant;
  logic [IW-1:0]            last_gnt;
  logic [LEN_MSB:LEN_LSB]   togo;

  logic [N_PORTS-1:0]       arb_gnt;
  logic [IW-1:0]            arb_idx;
  logic [DATA_W-1:0]        s_data [N_PORTS];
  logic [DATA_W-1:0]        sel_data;
  logic                     busy, sel_valid, hs, is_route, len_zero, last_word, abort;
  logic [LEN_MSB:LEN_LSB]   len;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack
    assign s_data[i] = S_AXIS_TDATA[DATA_W*i +: DATA_W];
  end

  rr_arbiter #(
    .N  (N_PORTS),
    .IW (IW)
  ) u_rr (
    .req      (S_AXIS_TVALID),
    .last_gnt (last_gnt),
    .gnt      (arb_gnt),
    .gnt_idx  (arb_idx)
  );

  // last_gnt doubles as the mux select while a packet is in flight.
  assign busy      = (state != ST_IDLE);
  assign sel_data  = s_data[last_gnt];
  assign sel_valid = busy && S_AXIS_TVALID[last_gnt];
  assign hs        = sel_valid && M_AXIS_TREADY;
  assign is_route  = (sel_data[TAG_MSB:TAG_LSB] == ROUTE_TAG);
  assign len       = sel_data[LEN_MSB:LEN_LSB];
  assign len_zero  = (len == '0);
  assign last_word = sel_valid &&
                     (((state == ST_HDR) && !is_route && len_zero) ||
                      ((state == ST_PAY) && (togo == 32'd1)));

`ifdef PKT_ARB_WDOG_EN
  localparam int unsigned SW = $clog2(TIMEOUT + 1);

  logic [SW-1:0] stall_cnt;
  logic          err_q;

  assign abort = busy && !hs && (stall_cnt == SW'(TIMEOUT - 1));
  assign ERR   = err_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      if (!busy || hs || abort) stall_cnt <= '0;
      else                      stall_cnt <= stall_cnt + SW'(1);
      if (abort) err_q <= 1'b1;
    end
  end
`else
  assign abort = 1'b0;
  assign ERR   = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (|S_AXIS_TVALID)     state_nxt = ST_HDR;
      ST_HDR:  if (hs && !is_route)    state_nxt = len_zero ? ST_IDLE : ST_PAY;
      ST_PAY:  if (hs && togo == 32'd1) state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_comb begin
    M_AXIS_TDATA  = busy ? sel_data : '0;
    M_AXIS_TVALID = sel_valid;
    M_AXIS_TLAST  = last_word;
    S_AXIS_TREADY = grant & {N_PORTS{M_AXIS_TREADY}};
    GRANT         = grant;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      grant    <= '0;
      last_gnt <= IW'(N_PORTS - 1);
      togo     <= '0;
    end else begin
      if (state == ST_IDLE && |S_AXIS_TVALID) begin
        grant    <= arb_gnt;
        last_gnt <= arb_idx;
      end else if (state_nxt == ST_IDLE) begin
        grant    <= '0;
      end
      // togo holds at 1 on the final word, so a full 32-bit length never wraps.
      if (hs && state == ST_HDR && !is_route && !len_zero)
        togo <= len;
      else if (hs && state == ST_PAY && togo != 32'd1)
        togo <= togo - 32'd1;
    end
  end

endmodule

// File: tb/tb_pkt_axis_arbiter.sv
// Directed self-checking bench for pkt_axis_arbiter (N_PORTS=4, TIMEOUT=16).
module tb_pkt_axis_arbiter;

  localparam int unsigned NP    = 4;
  localparam int unsigned DEPTH = 128;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic [64*NP-1:0]  S_AXIS_TDATA;
  logic [NP-1:0]     S_AXIS_TVALID;
  logic [NP-1:0]     S_AXIS_TREADY;
  logic [63:0]       M_AXIS_TDATA;
  logic              M_AXIS_TVALID;
  logic              M_AXIS_TLAST;
  logic              M_AXIS_TREADY = 1'b1;
  logic [NP-1:0]     GRANT;
  logic              ERR;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [63:0]  mem [NP][DEPTH];
  int unsigned  wr_cnt [NP] = '{default: 0};
  int unsigned  rd_ptr [NP] = '{default: 0};
  logic         gap    [NP] = '{default: 1'b0};

  logic         mon_en = 1'b0;
  logic [67:0]  got_q[$];
  logic [67:0]  exp_q[$];
  logic [63:0]  gp[$];
  logic [63:0]  ep[$];
  int unsigned  n_last = 0;

  int unsigned  ord [5] = '{0, 1, 2, 3, 0};
  int unsigned  budget;
  logic [63:0]  t1_exp [7];
  logic [63:0]  wexp;

  always #5 CLK = ~CLK;

  pkt_axis_arbiter #(
    .N_PORTS (NP),
    .TIMEOUT (16)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .GRANT         (GRANT),
    .ERR           (ERR)
  );

  // Source model: each port plays out its word list, advancing on handshake.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      S_AXIS_TDATA[64*p +: 64] = (rd_ptr[p] < wr_cnt[p]) ? mem[p][rd_ptr[p]] : 64'h0;
      S_AXIS_TVALID[p]         = (rd_ptr[p] < wr_cnt[p]) && !gap[p];
    end
  end

  always @(posedge CLK) begin
    for (int p = 0; p < NP; p++)
      if (S_AXIS_TVALID[p] && S_AXIS_TREADY[p]) rd_ptr[p] <= rd_ptr[p] + 1;
  end

  always @(posedge CLK) begin
    if (mon_en && M_AXIS_TVALID && M_AXIS_TREADY) begin
      for (int p = 0; p < NP; p++)
        if (GRANT[p]) got_q.push_back({4'(p), M_AXIS_TDATA});
      if (M_AXIS_TLAST) n_last <= n_last + 1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input int p, input logic [63:0] w);
    mem[p][wr_cnt[p]] = w;
    wr_cnt[p]++;
    exp_q.push_back({4'(p), w});
  endtask

  task automatic send_pkt(input int p, input int nroute, input int unsigned len, input logic [63:0] base);
    for (int i = 0; i < nroute; i++) push(p, 64'h0100_0000_0000_0000 | 64'(i));
    push(p, {32'h0000_0000, len});
    for (int unsigned i = 0; i < len; i++) push(p, base + 64'(i));
  endtask

  task automatic flush;
    for (int p = 0; p < NP; p++) wr_cnt[p] = rd_ptr[p];
  endtask

  task automatic do_reset;
    RST_N = 1'b0;
    #2;
    RST_N = 1'b1;
  endtask

  initial begin
    // Reset state
    #12;
    check_val("rst_tvalid", M_AXIS_TVALID, 0);
    check_val("rst_tlast",  M_AXIS_TLAST,  0);
    check_val("rst_tready", S_AXIS_TREADY, 0);
    check_val("rst_grant",  GRANT,         0);
    check_val("rst_err",    ERR,           0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick;

    // Single port 0: two routing words, len=4, four payload words
    t1_exp = '{64'h0100_0000_0000_0000, 64'h0100_0000_0000_0001, 64'h0000_0000_0000_0004,
               64'h5A00_0000_0000_00A0, 64'h5A00_0000_0000_00A1,
               64'h5A00_0000_0000_00A2, 64'h5A00_0000_0000_00A3};
    for (int k = 0; k < 7; k++) push(0, t1_exp[k]);
    check_val("t1_idle_valid", M_AXIS_TVALID, 0);
    check_val("t1_idle_grant", GRANT, 0);
    tick;
    for (int k = 0; k < 7; k++) begin
      check_val($sformatf("t1_data%0d", k),  M_AXIS_TDATA, t1_exp[k]);
      check_val($sformatf("t1_tlast%0d", k), M_AXIS_TLAST, (k == 6) ? 1 : 0);
      check_val($sformatf("t1_grant%0d", k), GRANT, 64'h1);
      tick;
    end
    check_val("t1_end_grant", GRANT, 0);
    check_val("t1_end_valid", M_AXIS_TVALID, 0);

    // All four ports requesting from reset: order 0,1,2,3,0 with one bubble each
    do_reset;
    for (int p = 0; p < NP; p++)
      send_pkt(p, 0, 2, 64'hC0DE_0000_0000_0000 + 64'(p * 256));
    send_pkt(0, 0, 2, 64'hC0DE_0000_0000_0010);
    for (int k = 0; k < 5; k++) begin
      check_val($sformatf("t2_bubble_valid%0d", k), M_AXIS_TVALID, 0);
      check_val($sformatf("t2_bubble_grant%0d", k), GRANT, 0);
      tick;
      for (int w = 0; w < 3; w++) begin
        wexp = (w == 0) ? 64'd2
             : 64'hC0DE_0000_0000_0000 + 64'(ord[k] * 256) + ((k == 4) ? 64'h10 : 64'h0) + 64'(w - 1);
        check_val($sformatf("t2_grant%0d_%0d", k, w), GRANT, 64'h1 << ord[k]);
        check_val($sformatf("t2_data%0d_%0d", k, w),  M_AXIS_TDATA, wexp);
        check_val($sformatf("t2_tlast%0d_%0d", k, w), M_AXIS_TLAST, (w == 2) ? 1 : 0);
        tick;
      end
    end

    // len=0 frame on port 1, then port 2 is served right after one bubble
    push(1, 64'h0100_0000_0000_0005);
    push(1, 64'h0000_0000_0000_0000);
    push(2, 64'h0000_0000_0000_0001);
    push(2, 64'h0000_0000_0000_7777);
    check_val("t3_idle_valid", M_AXIS_TVALID, 0);
    tick;
    check_val("t3_route_grant", GRANT, 64'h2);
    check_val("t3_route_data",  M_AXIS_TDATA, 64'h0100_0000_0000_0005);
    check_val("t3_route_tlast", M_AXIS_TLAST, 0);
    tick;
    check_val("t3_len0_data",  M_AXIS_TDATA, 64'h0);
    check_val("t3_len0_tlast", M_AXIS_TLAST, 1);
    tick;
    check_val("t3_bubble_grant", GRANT, 0);
    check_val("t3_bubble_valid", M_AXIS_TVALID, 0);
    tick;
    check_val("t3_p2_grant", GRANT, 64'h4);
    check_val("t3_p2_tlast0", M_AXIS_TLAST, 0);
    tick;
    check_val("t3_p2_data",  M_AXIS_TDATA, 64'h0000_0000_0000_7777);
    check_val("t3_p2_tlast", M_AXIS_TLAST, 1);
    tick;
    check_val("t3_end_grant", GRANT, 0);

    // Random sink backpressure and source gaps on ports 0 and 3
    exp_q.delete();
    got_q.delete();
    send_pkt(0, 1, 3, 64'h5A00_0000_0000_1000);
    send_pkt(3, 0, 2, 64'h5A00_0000_0000_3000);
    send_pkt(0, 0, 1, 64'h5A00_0000_0000_1100);
    send_pkt(3, 0, 0, 64'h0);
    send_pkt(0, 0, 2, 64'h5A00_0000_0000_1200);
    send_pkt(3, 2, 4, 64'h5A00_0000_0000_3200);
    mon_en = 1'b1;
    budget = 0;
    while (!(rd_ptr[0] == wr_cnt[0] && rd_ptr[3] == wr_cnt[3] && GRANT == '0) && budget < 2000) begin
      gap[0]        = ($urandom_range(0, 3) == 0);
      gap[3]        = ($urandom_range(0, 3) == 0);
      M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
      tick;
      budget++;
    end
    check_val("t4_budget", (budget < 2000) ? 1 : 0, 1);
    gap[0] = 1'b0;
    gap[3] = 1'b0;
    M_AXIS_TREADY = 1'b1;
    mon_en = 1'b0;
    for (int p = 0; p < NP; p++) begin
      ep.delete();
      gp.delete();
      foreach (exp_q[i]) if (exp_q[i][67:64] == 4'(p)) ep.push_back(exp_q[i][63:0]);
      foreach (got_q[i]) if (got_q[i][67:64] == 4'(p)) gp.push_back(got_q[i][63:0]);
      check_val($sformatf("t4_count_p%0d", p), gp.size(), ep.size());
      for (int i = 0; i < ep.size() && i < gp.size(); i++)
        check_val($sformatf("t4_word_p%0d_%0d", p, i), gp[i], ep[i]);
    end
    check_val("t4_tlast_count", n_last, 6);

    // Asynchronous reset in the middle of a payload
    send_pkt(2, 0, 5, 64'h5A00_0000_0000_2000);
    tick;
    tick;
    tick;
    check_val("t5_pre_valid", M_AXIS_TVALID, 1);
    check_val("t5_pre_data",  M_AXIS_TDATA, 64'h5A00_0000_0000_2001);
    #2;
    RST_N = 1'b0;
    #1;
    check_val("t5_rst_valid",  M_AXIS_TVALID, 0);
    check_val("t5_rst_tlast",  M_AXIS_TLAST,  0);
    check_val("t5_rst_tready", S_AXIS_TREADY, 0);
    check_val("t5_rst_grant",  GRANT,         0);
    RST_N = 1'b1;
    flush;
    send_pkt(1, 0, 1, 64'h5A00_0000_0000_5100);
    send_pkt(0, 0, 1, 64'h5A00_0000_0000_5000);
    check_val("t5_idle_valid", M_AXIS_TVALID, 0);
    tick;
    check_val("t5_first_grant", GRANT, 64'h1);
    repeat (5) tick;
    check_val("t5_end_grant", GRANT, 0);
    check_val("t5_end_valid", M_AXIS_TVALID, 0);

    // Source 0 stalls after its 2nd payload word; port 1 waiting behind it
    do_reset;
    send_pkt(0, 0, 4, 64'h5A00_0000_0000_6000);
    wr_cnt[0] = wr_cnt[0] - 2;
    send_pkt(1, 0, 1, 64'h5A00_0000_0000_6100);
    tick;
    check_val("t6_grant", GRANT, 64'h1);
    tick;
    tick;
    tick;
`ifdef PKT_ARB_WDOG_EN
    for (int c = 0; c < 16; c++) begin
      if (c == 0 || c == 15) begin
        check_val($sformatf("t6_stall_grant%0d", c), GRANT, 64'h1);
        check_val($sformatf("t6_stall_err%0d", c),   ERR, 0);
      end
      tick;
    end
    check_val("t6_abort_grant", GRANT, 0);
    check_val("t6_abort_err",   ERR, 1);
    check_val("t6_abort_valid", M_AXIS_TVALID, 0);
    tick;
    check_val("t6_next_grant", GRANT, 64'h2);
    tick;
    check_val("t6_next_tlast", M_AXIS_TLAST, 1);
    tick;
    check_val("t6_sticky_err", ERR, 1);
    check_val("t6_end_grant",  GRANT, 0);
`else
    repeat (40) tick;
    check_val("t6_hold_grant", GRANT, 64'h1);
    check_val("t6_hold_err",   ERR, 0);
    check_val("t6_hold_valid", M_AXIS_TVALID, 0);
    do_reset;
    check_val("t6_rst_grant", GRANT, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
